alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU (add/sub/and/xor) with per-result flags and condition-code register
module alu_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ifun,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic [2:0]       cc
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [1:0]       s1_fun_q;
    logic             s1_cc_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       flags_q;
    logic             s2_cc_q;
    logic [2:0]       cc_q;

    logic [WIDTH-1:0] result_d;
    logic             of_d;
    logic [2:0]       flags_d;

    logic out_fire;
    logic s1_adv;
    logic in_fire;

    assign out_fire = s2_valid_q & out_ready;
    assign s1_adv   = s1_valid_q & (~s2_valid_q | out_fire);
    assign in_ready = ~rst & (~s1_valid_q | s1_adv);
    assign in_fire  = in_valid & in_ready;

    // Outputs are forced to their reset values for the whole time rst is high,
    // not just after the reset edge.
    assign out_valid = s2_valid_q & ~rst;
    assign result    = rst ? '0 : result_q;
    assign flags     = rst ? 3'b000 : flags_q;
    assign cc        = rst ? 3'b100 : cc_q;

    always_comb begin
        result_d = '0;
        of_d     = 1'b0;
        case (s1_fun_q)
            2'd0: begin
                result_d = s1_a_q + s1_b_q;
                of_d     = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                           (result_d[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            2'd1: begin
                result_d = s1_b_q - s1_a_q;
                of_d     = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                           (result_d[WIDTH-1] != s1_b_q[WIDTH-1]);
            end
            2'd2:    result_d = s1_a_q & s1_b_q;
            default: result_d = s1_a_q ^ s1_b_q;
        endcase
        flags_d = {(result_d == '0), result_d[WIDTH-1], of_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_a_q   <= a;
            s1_b_q   <= b;
            s1_fun_q <= ifun;
            s1_cc_q  <= set_cc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= 3'b000;
            s2_cc_q    <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q <= 1'b1;
            result_q   <= result_d;
            flags_q    <= flags_d;
            s2_cc_q    <= s1_cc_q;
        end else if (out_fire) begin
            s2_valid_q <= 1'b0;
        end
    end

    // Condition codes commit only when the result actually leaves the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= 3'b100;
        end else if (out_fire && s2_cc_q) begin
            cc_q <= flags_q;
        end
    end

endmodule
